// File: rtl/tmds_serializer_mc.sv
// tmds_serializer_mc: multi-lane TMDS word serializer with a one-group input stage.
// One group is accepted per word slot. It is then shifted out OUT_BITS per cycle, LSB first,
// alongside a clock-lane pattern. IDLE_WORD is inserted when the stage is empty at a load edge.
module tmds_serializer_mc #(
  parameter int unsigned           NUM_LANES   = 3,
  parameter int unsigned           WORD_WIDTH  = 10,
  parameter int unsigned           OUT_BITS    = 1,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD   = 10'b1101010100,
  parameter logic [WORD_WIDTH-1:0] CLK_PATTERN = 10'b0000011111
) (
  input  logic                            tmds_clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*WORD_WIDTH-1:0] in_data,
  input  logic                            clr_underflow,
  output logic [NUM_LANES*OUT_BITS-1:0]   out_lanes,
  output logic [OUT_BITS-1:0]             out_clk,
  output logic                            out_word_start,
  output logic                            underflow_pulse,
  output logic                            underflow_sticky
);

  localparam int unsigned SLOTS  = WORD_WIDTH / OUT_BITS;
  localparam int unsigned LAST   = SLOTS - 1;
  localparam int unsigned CW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned GRP_W  = NUM_LANES * WORD_WIDTH;

  // Reject an output width that does not tile the symbol exactly
  if ((OUT_BITS == 0) || (WORD_WIDTH % OUT_BITS != 0)) begin : g_bad_out_bits
    $error("tmds_serializer_mc: OUT_BITS must divide WORD_WIDTH");
  end

  logic [CW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [GRP_W-1:0] lane_sr_q, lane_sr_d;
  logic [GRP_W-1:0] lane_shift_c;
  logic [WORD_WIDTH-1:0] clk_sr_q, clk_sr_d;
  logic [GRP_W-1:0] stg_q, stg_d;
  logic             stg_valid_q, stg_valid_d;
  logic             armed_q, armed_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic             word_start_q, word_start_d;
  logic             load_c;
  logic             accept_c;

  assign load_c   = (slot_cnt_q == CW'(LAST));
  assign in_ready = !stg_valid_q || load_c;
  assign accept_c = in_valid && in_ready;

  // Per-lane right shift with zero fill, and the per-lane output taps
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign lane_shift_c[n*WORD_WIDTH +: WORD_WIDTH] =
      lane_sr_q[n*WORD_WIDTH +: WORD_WIDTH] >> OUT_BITS;
    assign out_lanes[n*OUT_BITS +: OUT_BITS] = lane_sr_q[n*WORD_WIDTH +: OUT_BITS];
  end

  assign out_clk          = clk_sr_q[OUT_BITS-1:0];
  assign out_word_start   = word_start_q;
  assign underflow_pulse  = pulse_q;
  assign underflow_sticky = sticky_q;

  // Next-state: slot counter, shift/load of lanes and clock lane, stage fill/drain, underflow flags
  always_comb begin
    slot_cnt_d   = load_c ? '0 : slot_cnt_q + CW'(1);
    lane_sr_d    = lane_shift_c;
    clk_sr_d     = clk_sr_q >> OUT_BITS;
    stg_d        = stg_q;
    stg_valid_d  = stg_valid_q;
    armed_d      = armed_q || accept_c;
    pulse_d      = 1'b0;
    sticky_d     = sticky_q;
    word_start_d = load_c;

    if (load_c) begin
      clk_sr_d = CLK_PATTERN;
      if (stg_valid_q) begin
        lane_sr_d   = stg_q;
        stg_valid_d = 1'b0;
      end else begin
        lane_sr_d = {NUM_LANES{IDLE_WORD}};
        pulse_d   = armed_q;
      end
    end

    // A word accepted on an idle-insert edge lands in the stage only
    if (accept_c) begin
      stg_d       = in_data;
      stg_valid_d = 1'b1;
    end

    // A new underflow takes priority over a clear on the same edge
    if (pulse_d) begin
      sticky_d = 1'b1;
    end else if (clr_underflow) begin
      sticky_d = 1'b0;
    end
  end

  // State registers; reset parks the counter on LAST so the first edge is a load edge
  always_ff @(posedge tmds_clk or posedge reset) begin
    if (reset) begin
      slot_cnt_q   <= CW'(LAST);
      lane_sr_q    <= '0;
      clk_sr_q     <= '0;
      stg_q        <= '0;
      stg_valid_q  <= 1'b0;
      armed_q      <= 1'b0;
      pulse_q      <= 1'b0;
      sticky_q     <= 1'b0;
      word_start_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      lane_sr_q    <= lane_sr_d;
      clk_sr_q     <= clk_sr_d;
      stg_q        <= stg_d;
      stg_valid_q  <= stg_valid_d;
      armed_q      <= armed_d;
      pulse_q      <= pulse_d;
      sticky_q     <= sticky_d;
      word_start_q <= word_start_d;
    end
  end

endmodule

// File: tb/tb_tmds_serializer_mc.sv
// Directed bench for tmds_serializer_mc: an SDR instance (OUT_BITS=1) and a 2-bit instance.
module tb_tmds_serializer_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        s_valid, s_ready, s_clr;
  logic [29:0] s_data;
  logic [2:0]  s_lanes;
  logic [0:0]  s_oclk;
  logic        s_ws, s_pulse, s_sticky;

  logic        d_valid, d_ready, d_clr;
  logic [29:0] d_data;
  logic [5:0]  d_lanes;
  logic [1:0]  d_oclk;
  logic        d_ws, d_pulse, d_sticky;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] idle_w = 10'b1101010100;
  logic [9:0] clkp_w = 10'b0000011111;

  tmds_serializer_mc #(.NUM_LANES(3), .WORD_WIDTH(10), .OUT_BITS(1)) u_sdr (
    .tmds_clk(clk), .reset(reset), .in_valid(s_valid), .in_ready(s_ready),
    .in_data(s_data), .clr_underflow(s_clr), .out_lanes(s_lanes), .out_clk(s_oclk),
    .out_word_start(s_ws), .underflow_pulse(s_pulse), .underflow_sticky(s_sticky)
  );

  tmds_serializer_mc #(.NUM_LANES(3), .WORD_WIDTH(10), .OUT_BITS(2)) u_ddr (
    .tmds_clk(clk), .reset(reset), .in_valid(d_valid), .in_ready(d_ready),
    .in_data(d_data), .clr_underflow(d_clr), .out_lanes(d_lanes), .out_clk(d_oclk),
    .out_word_start(d_ws), .underflow_pulse(d_pulse), .underflow_sticky(d_sticky)
  );

  // Advance to the next falling edge; cyc counts cycles since reset release
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int sdr_slot();
    return (cyc + 9) % 10;
  endfunction

  function automatic int ddr_slot();
    return (cyc + 4) % 5;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b0; s_clr = 1'b0; s_data = '0;
    d_valid = 1'b0; d_clr = 1'b0; d_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (s_lanes !== 3'b000) begin failures++; $display("FAIL reset_lanes got=%b exp=000", s_lanes); end
    checks++; if (s_oclk !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b exp=0", s_oclk); end
    checks++; if (s_ws !== 1'b0) begin failures++; $display("FAIL reset_ws got=%b exp=0", s_ws); end
    checks++; if (s_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", s_pulse); end
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", s_sticky); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
    checks++; if (d_lanes !== 6'b0) begin failures++; $display("FAIL reset_ddr_lanes got=%b exp=000000", d_lanes); end
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL reset_ddr_ready got=%b exp=1", d_ready); end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_idle_sdr();
    int b;
    for (int i = 0; i < 30; i++) begin
      tick();
      b = sdr_slot();
      checks++; if (s_lanes !== {3{idle_w[b]}}) begin failures++; $display("FAIL idle_lanes cyc=%0d got=%b exp=%b", cyc, s_lanes, {3{idle_w[b]}}); end
      checks++; if (s_oclk[0] !== clkp_w[b]) begin failures++; $display("FAIL idle_clk cyc=%0d got=%b exp=%b", cyc, s_oclk, clkp_w[b]); end
      checks++; if (s_ws !== (b == 0)) begin failures++; $display("FAIL idle_ws cyc=%0d got=%b exp=%b", cyc, s_ws, (b == 0)); end
      checks++; if (s_pulse !== 1'b0) begin failures++; $display("FAIL idle_pulse cyc=%0d got=%b exp=0", cyc, s_pulse); end
    end
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL idle_sticky got=%b exp=0", s_sticky); end
  endtask

  task automatic test_first_word();
    logic [9:0] l0, l1, l2;
    int b;
    l0 = 10'h2AB; l1 = 10'h155; l2 = 10'h3FF;
    for (int i = 0; i < 10 && sdr_slot() != 3; i++) tick();
    s_data = {l2, l1, l0};
    s_valid = 1'b1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL first_ready got=%b exp=1", s_ready); end
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin s_valid = 1'b0; s_data = '0; end
      if (i < 7) begin
        checks++; if (s_ws !== 1'b0) begin failures++; $display("FAIL first_early_ws i=%0d got=%b exp=0", i, s_ws); end
      end else begin
        b = i - 7;
        checks++; if (s_lanes !== {l2[b], l1[b], l0[b]}) begin failures++; $display("FAIL first_lanes bit=%0d got=%b exp=%b", b, s_lanes, {l2[b], l1[b], l0[b]}); end
        checks++; if (s_ws !== (b == 0)) begin failures++; $display("FAIL first_ws bit=%0d got=%b exp=%b", b, s_ws, (b == 0)); end
      end
    end
  endtask

  task automatic test_underflow();
    tick();
    checks++; if (s_pulse !== 1'b1) begin failures++; $display("FAIL uf_pulse got=%b exp=1", s_pulse); end
    checks++; if (s_sticky !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", s_sticky); end
    checks++; if (s_lanes !== 3'b000) begin failures++; $display("FAIL uf_idle_lanes got=%b exp=000", s_lanes); end
    tick();
    checks++; if (s_pulse !== 1'b0) begin failures++; $display("FAIL uf_pulse_len got=%b exp=0", s_pulse); end
    checks++; if (s_sticky !== 1'b1) begin failures++; $display("FAIL uf_sticky_hold got=%b exp=1", s_sticky); end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", s_sticky); end
    for (int i = 0; i < 10 && sdr_slot() != 9; i++) tick();
    s_clr = 1'b1;
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL uf_pre_collide got=%b exp=0", s_sticky); end
    tick();
    s_clr = 1'b0;
    checks++; if (s_pulse !== 1'b1) begin failures++; $display("FAIL uf_collide_pulse got=%b exp=1", s_pulse); end
    checks++; if (s_sticky !== 1'b1) begin failures++; $display("FAIL uf_collide_sticky got=%b exp=1", s_sticky); end
    tick();
    checks++; if (s_sticky !== 1'b1) begin failures++; $display("FAIL uf_collide_hold got=%b exp=1", s_sticky); end
  endtask

  task automatic test_stage_full();
    logic [29:0] ga, gb, gc, w;
    int b;
    ga = {10'h2CD, 10'h123, 10'h0F0};
    gb = {10'h05A, 10'h3A5, 10'h00F};
    gc = {10'h222, 10'h111, 10'h3C3};
    for (int i = 0; i < 10 && sdr_slot() != 2; i++) tick();
    s_data = ga;
    s_valid = 1'b1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL stage_ready_empty got=%b exp=1", s_ready); end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (s_ready !== (sdr_slot() == 9)) begin failures++; $display("FAIL stage_ready slot=%0d got=%b exp=%b", sdr_slot(), s_ready, (sdr_slot() == 9)); end
      s_data = (sdr_slot() == 9) ? gb : gc;
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin s_valid = 1'b0; s_data = '0; end
      b = i % 10;
      w = (i < 10) ? ga : gb;
      checks++; if (s_lanes !== {w[20+b], w[10+b], w[b]}) begin failures++; $display("FAIL stage_lanes i=%0d got=%b exp=%b", i, s_lanes, {w[20+b], w[10+b], w[b]}); end
      checks++; if (s_ws !== (b == 0)) begin failures++; $display("FAIL stage_ws i=%0d got=%b exp=%b", i, s_ws, (b == 0)); end
    end
  endtask

  task automatic test_ddr_stream();
    logic [9:0] wk;
    logic [5:0] exp_l;
    int b;
    for (int i = 0; i < 5 && ddr_slot() != 4; i++) tick();
    wk = 10'h0A5;
    d_data = {20'b0, wk};
    d_valid = 1'b1;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL ddr_ready_start got=%b exp=1", d_ready); end
    for (int j = 1; j <= 30; j++) begin
      tick();
      b = ddr_slot();
      checks++; if (d_ready !== (b == 4)) begin failures++; $display("FAIL ddr_ready j=%0d got=%b exp=%b", j, d_ready, (b == 4)); end
      if (j <= 5) begin
        exp_l = {3{idle_w[2*b +: 2]}};
      end else begin
        wk = 10'h0A5 + 10'((j - 6) / 5);
        exp_l = {4'b0, wk[2*b +: 2]};
      end
      checks++; if (d_lanes !== exp_l) begin failures++; $display("FAIL ddr_lanes j=%0d got=%b exp=%b", j, d_lanes, exp_l); end
      checks++; if (d_oclk !== clkp_w[2*b +: 2]) begin failures++; $display("FAIL ddr_clk j=%0d got=%b exp=%b", j, d_oclk, clkp_w[2*b +: 2]); end
      checks++; if (d_ws !== (b == 0)) begin failures++; $display("FAIL ddr_ws j=%0d got=%b exp=%b", j, d_ws, (b == 0)); end
      checks++; if (d_pulse !== 1'b0) begin failures++; $display("FAIL ddr_pulse j=%0d got=%b exp=0", j, d_pulse); end
      wk = 10'h0A5 + 10'((j + 4) / 5);
      d_data = {20'b0, wk};
    end
    d_valid = 1'b0;
    checks++; if (d_sticky !== 1'b0) begin failures++; $display("FAIL ddr_sticky got=%b exp=0", d_sticky); end
  endtask

  task automatic test_reset_midword();
    int b;
    for (int i = 0; i < 10 && sdr_slot() != 2; i++) tick();
    s_data = {10'h3E1, 10'h0C7, 10'h1B6};
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (s_lanes !== 3'b000) begin failures++; $display("FAIL mid_lanes got=%b exp=000", s_lanes); end
    checks++; if (s_oclk !== 1'b0) begin failures++; $display("FAIL mid_clk got=%b exp=0", s_oclk); end
    checks++; if (s_ws !== 1'b0) begin failures++; $display("FAIL mid_ws got=%b exp=0", s_ws); end
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL mid_sticky got=%b exp=0", s_sticky); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", s_ready); end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      b = sdr_slot();
      checks++; if (s_lanes !== {3{idle_w[b]}}) begin failures++; $display("FAIL mid_idle cyc=%0d got=%b exp=%b", cyc, s_lanes, {3{idle_w[b]}}); end
      checks++; if (s_pulse !== 1'b0) begin failures++; $display("FAIL mid_pulse cyc=%0d got=%b exp=0", cyc, s_pulse); end
    end
    checks++; if (s_sticky !== 1'b0) begin failures++; $display("FAIL mid_sticky_after got=%b exp=0", s_sticky); end
  endtask

  initial begin
    test_reset();
    test_idle_sdr();
    test_first_word();
    test_underflow();
    test_stage_full();
    test_ddr_stream();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
